// File: rtl/scg_pkg.sv
// Shared definitions for the SDRAM command generator: command codes, timing defaults
// and a counter sizing helper.
package scg_pkg;

  typedef enum logic [3:0] {
    CMD_NOP          = 4'd0,
    CMD_ACTIVE       = 4'd1,
    CMD_READ         = 4'd2,
    CMD_WRITE        = 4'd3,
    CMD_PRECHARGE    = 4'd4,
    CMD_AUTO_REFRESH = 4'd5,
    CMD_SELF_REF     = 4'd6,
    CMD_LOAD_MODE    = 4'd7,
    CMD_SREF_EXIT    = 4'd8
  } scg_cmd_e;

  localparam int unsigned T_XSR_DEF = 10;
  localparam int unsigned T_RFC_DEF = 7;

  // Bits needed to hold (max - 1) of the three values, never less than one.
  function automatic int unsigned cnt_width(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/scg_delay_cnt.sv
// Loadable down-counter with a zero flag; holds at zero rather than wrapping.
module scg_delay_cnt #(
  parameter int unsigned Width = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - Width'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/scg_self_ref_exit.sv
// Self-refresh exit sequencer: SREF_EXIT, tXSR of NOPs, then N_AREF auto-refreshes each
// followed by tRFC of NOPs, finishing with a level-held start/done handshake.
module scg_self_ref_exit
  import scg_pkg::*;
#(
  parameter int unsigned T_XSR  = T_XSR_DEF,
  parameter int unsigned T_RFC  = T_RFC_DEF,
  parameter int unsigned N_AREF = 2
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       start,
  output logic       done,
  output logic [3:0] command,
  output logic       cke_req
);

  localparam int unsigned    CntW     = cnt_width(T_XSR, T_RFC, N_AREF);
  localparam logic [CntW-1:0] XsrLoad  = CntW'(T_XSR - 1);
  localparam logic [CntW-1:0] RfcLoad  = CntW'(T_RFC - 1);
  localparam logic [CntW-1:0] ArefLoad = CntW'((N_AREF > 0) ? N_AREF - 1 : 0);
  localparam bit              HasAref  = (N_AREF > 0);

  typedef enum logic [2:0] {
    StIdle, StExit, StWaitXsr, StAref, StWaitRfc, StDone
  } state_e;

  state_e          state_q, state_d;
  scg_cmd_e        command_q;
  logic            cke_q, done_q;
  logic            wait_load, wait_dec, wait_zero;
  logic            ref_load, ref_dec, ref_zero;
  logic [CntW-1:0] wait_val;

  scg_delay_cnt #(.Width(CntW)) u_wait_cnt (
    .clk      (clk),
    .n_rst    (n_rst),
    .load     (wait_load),
    .load_val (wait_val),
    .dec      (wait_dec),
    .zero     (wait_zero)
  );

  scg_delay_cnt #(.Width(CntW)) u_ref_cnt (
    .clk      (clk),
    .n_rst    (n_rst),
    .load     (ref_load),
    .load_val (ArefLoad),
    .dec      (ref_dec),
    .zero     (ref_zero)
  );

  always_comb begin
    state_d   = state_q;
    wait_load = 1'b0;
    wait_val  = '0;
    wait_dec  = 1'b0;
    ref_load  = 1'b0;
    ref_dec   = 1'b0;
    unique case (state_q)
      StIdle: if (start) state_d = StExit;
      StExit: begin
        wait_load = 1'b1;
        wait_val  = XsrLoad;
        state_d   = StWaitXsr;
      end
      StWaitXsr: begin
        if (!wait_zero) begin
          wait_dec = 1'b1;
        end else if (HasAref) begin
          ref_load = 1'b1;
          state_d  = StAref;
        end else begin
          state_d = StDone;
        end
      end
      StAref: begin
        wait_load = 1'b1;
        wait_val  = RfcLoad;
        state_d   = StWaitRfc;
      end
      StWaitRfc: begin
        if (!wait_zero) begin
          wait_dec = 1'b1;
        end else if (ref_zero) begin
          state_d = StDone;
        end else begin
          ref_dec = 1'b1;
          state_d = StAref;
        end
      end
      StDone: if (!start) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they always match the current state.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= StIdle;
      command_q <= CMD_NOP;
      cke_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      command_q <= (state_d == StExit) ? CMD_SREF_EXIT :
                   (state_d == StAref) ? CMD_AUTO_REFRESH : CMD_NOP;
      cke_q     <= (state_d != StIdle);
      done_q    <= (state_d == StDone);
    end
  end

  assign command = command_q;
  assign cke_req = cke_q;
  assign done    = done_q;

endmodule

// File: tb/tb_scg_self_ref_exit.sv
// Bench for scg_self_ref_exit: a default instance and a no-refresh instance share stimulus
// and are checked every cycle against a timeline model plus literal spot checks.
module tb_scg_self_ref_exit;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       start;
  logic       a_done, b_done, a_cke, b_cke;
  logic [3:0] a_cmd, b_cmd;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int ta = 0;
  int tb = 0;

  localparam int A_XSR = 10, A_RFC = 7, A_NAREF = 2;
  localparam int B_XSR = 3,  B_RFC = 7, B_NAREF = 0;
  localparam int A_DONE = 2 + A_XSR + A_NAREF * (1 + A_RFC);
  localparam int B_DONE = 2 + B_XSR + B_NAREF * (1 + B_RFC);

  always #5 clk = ~clk;

  scg_self_ref_exit u_dut_a (
    .clk     (clk),
    .n_rst   (n_rst),
    .start   (start),
    .done    (a_done),
    .command (a_cmd),
    .cke_req (a_cke)
  );

  scg_self_ref_exit #(.T_XSR(B_XSR), .T_RFC(B_RFC), .N_AREF(B_NAREF)) u_dut_b (
    .clk     (clk),
    .n_rst   (n_rst),
    .start   (start),
    .done    (b_done),
    .command (b_cmd),
    .cke_req (b_cke)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Model position: 0 = idle, otherwise cycle number within the current sequence.
  function automatic int model_next(int t, bit st, int done_t);
    if (t == 0) return st ? 1 : 0;
    if (t >= done_t) return st ? t : 0;
    return t + 1;
  endfunction

  function automatic int exp_cmd(int t, int txsr, int trfc, int naref);
    if (t == 1) return 8;
    for (int k = 0; k < naref; k++) begin
      if (t == 2 + txsr + k * (1 + trfc)) return 5;
    end
    return 0;
  endfunction

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ta = 0;
      tb = 0;
    end else begin
      ta = model_next(ta, start, A_DONE);
      tb = model_next(tb, start, B_DONE);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("a_command", a_cmd, exp_cmd(ta, A_XSR, A_RFC, A_NAREF));
      chk("a_cke_req", a_cke, (ta != 0) ? 1 : 0);
      chk("a_done",    a_done, (ta == A_DONE) ? 1 : 0);
      chk("b_command", b_cmd, exp_cmd(tb, B_XSR, B_RFC, B_NAREF));
      chk("b_cke_req", b_cke, (tb != 0) ? 1 : 0);
      chk("b_done",    b_done, (tb == B_DONE) ? 1 : 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_rst = 1'b0;
    start = 1'b0;
    tick();
    tick();
    n_rst  = 1'b1;
    chk_en = 1'b1;
    chk("rst_cmd", a_cmd, 0);
    chk("rst_cke", a_cke, 0);
    chk("rst_done", a_done, 0);
    repeat (10) tick();

    // Held start, then back-to-back restart: drop at 30, raise at 32.
    start = 1'b1;
    for (int c = 1; c <= 33; c++) begin
      tick();
      case (c)
        1: begin
          chk("lit_a_exit", a_cmd, 8);
          chk("lit_a_cke1", a_cke, 1);
          chk("lit_b_exit", b_cmd, 8);
        end
        4: begin
          chk("lit_b_nop4", b_cmd, 0);
          chk("lit_b_done4", b_done, 0);
        end
        5: chk("lit_b_done5", b_done, 1);
        11: chk("lit_a_nop11", a_cmd, 0);
        12: chk("lit_a_aref12", a_cmd, 5);
        20: chk("lit_a_aref20", a_cmd, 5);
        27: chk("lit_a_done27", a_done, 0);
        28: chk("lit_a_done28", a_done, 1);
        30: begin
          chk("lit_a_done30", a_done, 1);
          start = 1'b0;
        end
        31: begin
          chk("lit_a_idle31", a_cke, 0);
          chk("lit_a_nodone31", a_done, 0);
        end
        32: start = 1'b1;
        33: chk("lit_a_exit33", a_cmd, 8);
        default: ;
      endcase
    end

    // Reset during sequence cycle 15 (tRFC wait) of the restarted sequence.
    repeat (14) tick();
    n_rst = 1'b0;
    #1;
    chk("lit_rst_cmd", a_cmd, 0);
    chk("lit_rst_cke", a_cke, 0);
    chk("lit_rst_done", a_done, 0);
    tick();
    n_rst = 1'b1;

    // Fresh sequence with start high only at the first sampling edge.
    for (int c = 1; c <= 32; c++) begin
      tick();
      case (c)
        1: begin
          chk("lit_p_exit", a_cmd, 8);
          start = 1'b0;
        end
        5: chk("lit_p_b_done5", b_done, 1);
        6: chk("lit_p_b_idle6", b_cke, 0);
        12: chk("lit_p_aref12", a_cmd, 5);
        27: chk("lit_p_done27", a_done, 0);
        28: chk("lit_p_done28", a_done, 1);
        29: begin
          chk("lit_p_done29", a_done, 0);
          chk("lit_p_cke29", a_cke, 0);
        end
        default: ;
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
